// File: rtl/sched_pkg.sv
// Shared encodings for the round-robin process scheduler:
// table entry states, context-exchange codes and FSM states.
package sched_pkg;

  typedef enum logic [1:0] {
    E_FREE    = 2'b00,
    E_READY   = 2'b01,
    E_RUNNING = 2'b10,
    E_WAITING = 2'b11
  } entry_e;

  typedef enum logic [1:0] {
    CXC_NONE   = 2'd0,
    CXC_CHANGE = 2'd1,
    CXC_WAIT   = 2'd2,
    CXC_HALT   = 2'd3
  } cxc_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RETIRE,
    S_SEARCH,
    S_GRANT,
    S_STALL
  } fsm_e;

  function automatic entry_e retire_state(input cxc_e c);
    entry_e r;
    case (c)
      CXC_CHANGE: r = E_READY;
      CXC_WAIT:   r = E_WAITING;
      default:    r = E_FREE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/process_table.sv
// Per-process state table: one FSM write port beating IO_DONE
// beating CREATE, with a READY bitmap and one probe read port.
module process_table
  import sched_pkg::*;
#(
  parameter int NUM_PROCESSES = 8,
  parameter int PID_WIDTH     = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_fsm_we,
  input  logic [PID_WIDTH-1:0]     i_fsm_idx,
  input  entry_e                   i_fsm_data,
  input  logic                     i_create_en,
  input  logic [PID_WIDTH-1:0]     i_create_pid,
  input  logic                     i_io_en,
  input  logic [PID_WIDTH-1:0]     i_io_pid,
  input  logic [PID_WIDTH-1:0]     i_rd_idx,
  output entry_e                   o_rd_state,
  output logic [NUM_PROCESSES-1:0] o_ready_mask
);

  entry_e r_tbl [NUM_PROCESSES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_PROCESSES; i++)
        r_tbl[i] <= (i == 0) ? E_RUNNING : E_FREE;
    end else begin
      for (int i = 0; i < NUM_PROCESSES; i++) begin
        if (i_fsm_we && i_fsm_idx == PID_WIDTH'(i))
          r_tbl[i] <= i_fsm_data;
        else if (i_io_en && i_io_pid == PID_WIDTH'(i)
                 && r_tbl[i] == E_WAITING)
          r_tbl[i] <= E_READY;
        else if (i_create_en && i_create_pid == PID_WIDTH'(i)
                 && r_tbl[i] == E_FREE)
          r_tbl[i] <= E_READY;
      end
    end
  end

  always_comb begin
    o_ready_mask = '0;
    for (int i = 0; i < NUM_PROCESSES; i++)
      o_ready_mask[i] = (r_tbl[i] == E_READY);
  end

  assign o_rd_state = r_tbl[i_rd_idx];

endmodule

// File: rtl/process_scheduler.sv
// Round-robin scheduler: retires the running process on a context
// exchange, then probes forward one entry per cycle for the next READY.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROCESSES = 8,
  parameter int PID_WIDTH     = 3,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     WCLOCK,
  input  logic                     RESET,
  input  logic                     LOAD_CXC,
  input  logic [DATA_WIDTH-1:0]    CXC_REGISTER,
  input  logic                     CREATE_EN,
  input  logic [PID_WIDTH-1:0]     CREATE_PID,
  input  logic                     IO_DONE_EN,
  input  logic [PID_WIDTH-1:0]     IO_DONE_PID,
  output logic [PID_WIDTH-1:0]     CURRENT_PID,
  output logic                     SCHED_DONE,
  output logic                     NO_READY,
  output logic [NUM_PROCESSES-1:0] READY_MASK
);

  localparam logic [PID_WIDTH-1:0] K_LAST = PID_WIDTH'(NUM_PROCESSES - 1);

  fsm_e                 r_state;
  fsm_e                 w_state_nxt;
  cxc_e                 r_code;
  logic [PID_WIDTH-1:0] r_k;
  logic [PID_WIDTH-1:0] r_cur_pid;
  logic [PID_WIDTH-1:0] r_grant_pid;
  logic                 r_sched_done;
  logic                 r_no_ready;

  cxc_e                 w_code;
  logic [PID_WIDTH-1:0] w_probe_idx;
  entry_e               w_probe_state;
  logic                 w_hit;
  logic                 w_we;
  logic [PID_WIDTH-1:0] w_widx;
  entry_e               w_wdata;
  logic                 w_unused_cxc;

  assign w_code       = cxc_e'(CXC_REGISTER[1:0]);
  assign w_unused_cxc = ^CXC_REGISTER[DATA_WIDTH-1:2];
  assign w_probe_idx  = r_cur_pid + PID_WIDTH'(1) + r_k;
  assign w_hit        = (w_probe_state == E_READY);

  process_table #(
    .NUM_PROCESSES(NUM_PROCESSES),
    .PID_WIDTH    (PID_WIDTH)
  ) u_table (
    .i_clk        (WCLOCK),
    .i_rst        (RESET),
    .i_fsm_we     (w_we),
    .i_fsm_idx    (w_widx),
    .i_fsm_data   (w_wdata),
    .i_create_en  (CREATE_EN),
    .i_create_pid (CREATE_PID),
    .i_io_en      (IO_DONE_EN),
    .i_io_pid     (IO_DONE_PID),
    .i_rd_idx     (w_probe_idx),
    .o_rd_state   (w_probe_state),
    .o_ready_mask (READY_MASK)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_widx      = r_cur_pid;
    w_wdata     = E_FREE;
    case (r_state)
      S_IDLE:
        if (LOAD_CXC && w_code != CXC_NONE)
          w_state_nxt = S_RETIRE;
      S_RETIRE: begin
        w_we        = 1'b1;
        w_wdata     = retire_state(r_code);
        w_state_nxt = S_SEARCH;
      end
      S_SEARCH:
        if (w_hit)
          w_state_nxt = S_GRANT;
        else if (r_k == K_LAST)
          w_state_nxt = S_STALL;
      S_GRANT: begin
        w_we        = 1'b1;
        w_widx      = r_grant_pid;
        w_wdata     = E_RUNNING;
        w_state_nxt = S_IDLE;
      end
      S_STALL:
        if (|READY_MASK)
          w_state_nxt = S_SEARCH;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge WCLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_code       <= CXC_NONE;
      r_k          <= '0;
      r_cur_pid    <= '0;
      r_grant_pid  <= '0;
      r_sched_done <= 1'b0;
      r_no_ready   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sched_done <= (r_state == S_GRANT);
      case (r_state)
        S_IDLE:
          if (w_state_nxt == S_RETIRE)
            r_code <= w_code;
        S_RETIRE:
          r_k <= '0;
        S_SEARCH:
          if (w_hit)
            r_grant_pid <= w_probe_idx;
          else if (r_k == K_LAST)
            r_no_ready <= 1'b1;
          else
            r_k <= r_k + PID_WIDTH'(1);
        S_GRANT: begin
          r_cur_pid  <= r_grant_pid;
          r_no_ready <= 1'b0;
        end
        S_STALL:
          if (|READY_MASK)
            r_k <= '0;
        default: ;
      endcase
    end
  end

  assign CURRENT_PID = r_cur_pid;
  assign SCHED_DONE  = r_sched_done;
  assign NO_READY    = r_no_ready;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: hand-computed grant latencies,
// PIDs, READY bitmaps and stall/reset behaviour.
module tb_process_scheduler;

  logic        WCLOCK = 1'b0;
  logic        RESET;
  logic        LOAD_CXC;
  logic [31:0] CXC_REGISTER;
  logic        CREATE_EN;
  logic [2:0]  CREATE_PID;
  logic        IO_DONE_EN;
  logic [2:0]  IO_DONE_PID;
  logic [2:0]  CURRENT_PID;
  logic        SCHED_DONE;
  logic        NO_READY;
  logic [7:0]  READY_MASK;

  int errors = 0;
  int checks = 0;
  int n;

  process_scheduler dut (
    .WCLOCK      (WCLOCK),
    .RESET       (RESET),
    .LOAD_CXC    (LOAD_CXC),
    .CXC_REGISTER(CXC_REGISTER),
    .CREATE_EN   (CREATE_EN),
    .CREATE_PID  (CREATE_PID),
    .IO_DONE_EN  (IO_DONE_EN),
    .IO_DONE_PID (IO_DONE_PID),
    .CURRENT_PID (CURRENT_PID),
    .SCHED_DONE  (SCHED_DONE),
    .NO_READY    (NO_READY),
    .READY_MASK  (READY_MASK)
  );

  always #5 WCLOCK = ~WCLOCK;

  task automatic tick();
    @(negedge WCLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count negedges until SCHED_DONE, starting from n0; stops at limit.
  task automatic wait_done(input int n0, input int limit, output int nout);
    nout = n0;
    do begin
      tick();
      nout++;
    end while (!SCHED_DONE && nout < limit);
  endtask

  task automatic create(input logic [2:0] pid);
    CREATE_EN = 1'b1; CREATE_PID = pid;
    tick();
    CREATE_EN = 1'b0;
  endtask

  task automatic io_done(input logic [2:0] pid);
    IO_DONE_EN = 1'b1; IO_DONE_PID = pid;
    tick();
    IO_DONE_EN = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  initial begin
    RESET = 1'b1; LOAD_CXC = 1'b0; CXC_REGISTER = '0;
    CREATE_EN = 1'b0; CREATE_PID = '0;
    IO_DONE_EN = 1'b0; IO_DONE_PID = '0;
    do_reset();
    chk("rst_pid",  32'(CURRENT_PID), 0);
    chk("rst_done", 32'(SCHED_DONE), 0);
    chk("rst_nordy", 32'(NO_READY), 0);
    chk("rst_mask", 32'(READY_MASK), 0);

    // CHANGE from pid 0 with 3 and 5 READY: hit pid 3 at k=2
    create(3'd3);
    create(3'd5);
    chk("create_mask", 32'(READY_MASK), 32'h28);
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd1;
    tick();
    LOAD_CXC = 1'b0;
    chk("t1_nodone_early", 32'(SCHED_DONE), 0);
    wait_done(1, 20, n);
    chk("t1_latency", n, 6);
    chk("t1_pid", 32'(CURRENT_PID), 3);
    chk("t1_mask", 32'(READY_MASK), 32'h21);
    tick();
    chk("t1_pulse_end", 32'(SCHED_DONE), 0);

    // WAIT from pid 3: probes 4,5 -> pid 5 at k=1
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd2;
    tick();
    LOAD_CXC = 1'b0;
    wait_done(1, 20, n);
    chk("t2_latency", n, 5);
    chk("t2_pid", 32'(CURRENT_PID), 5);
    chk("t2_mask", 32'(READY_MASK), 32'h01);
    io_done(3'd3);
    chk("t2_io_mask", 32'(READY_MASK), 32'h09);

    // Ignored requests: IO_DONE on RUNNING, CREATE on READY, code 0 / 4
    io_done(3'd5);
    chk("ign_io_run", 32'(READY_MASK), 32'h09);
    create(3'd0);
    chk("ign_create_rdy", 32'(READY_MASK), 32'h09);
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd0;
    tick();
    CXC_REGISTER = 32'd4;
    tick();
    LOAD_CXC = 1'b0;
    wait_done(0, 12, n);
    chk("ign_code0_done", 32'(SCHED_DONE), 0);
    chk("ign_code0_pid", 32'(CURRENT_PID), 5);
    chk("ign_code0_mask", 32'(READY_MASK), 32'h09);

    // CHANGE from 5: probes 6,7,0 -> pid 0; HALT sent mid-SEARCH is dropped
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd1;
    tick();
    LOAD_CXC = 1'b0;
    tick();
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd3;
    tick();
    LOAD_CXC = 1'b0;
    if (SCHED_DONE) n = 3;
    else wait_done(3, 20, n);
    chk("t5_latency", n, 6);
    chk("t5_pid", 32'(CURRENT_PID), 0);
    chk("t5_mask", 32'(READY_MASK), 32'h28);
    wait_done(0, 12, n);
    chk("t5_no_extra", 32'(SCHED_DONE), 0);
    chk("t5_mask_hold", 32'(READY_MASK), 32'h28);

    // RESET during SEARCH (grant would be pid 3)
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd1;
    tick();
    LOAD_CXC = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    chk("mid_rst_pid", 32'(CURRENT_PID), 0);
    chk("mid_rst_done", 32'(SCHED_DONE), 0);
    chk("mid_rst_nordy", 32'(NO_READY), 0);
    chk("mid_rst_mask", 32'(READY_MASK), 0);
    RESET = 1'b0;
    wait_done(0, 12, n);
    chk("mid_rst_lost", 32'(SCHED_DONE), 0);

    // HALT of the only process: 8 probes then STALL, no grant
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd3;
    tick();
    LOAD_CXC = 1'b0;
    n = 1;
    while (!NO_READY && n < 20) begin
      tick();
      n++;
    end
    chk("halt_stall_lat", n, 10);
    wait_done(n, 16, n);
    chk("halt_no_done", 32'(SCHED_DONE), 0);
    chk("halt_nordy", 32'(NO_READY), 1);
    chk("halt_mask", 32'(READY_MASK), 0);
    // CREATE 6 releases the stall: probes 1..6 from stale pid 0
    create(3'd6);
    wait_done(1, 20, n);
    chk("stall_rel_lat", n, 9);
    chk("stall_rel_pid", 32'(CURRENT_PID), 6);
    chk("stall_rel_nordy", 32'(NO_READY), 0);
    chk("stall_rel_mask", 32'(READY_MASK), 0);

    // CHANGE with only pid 0 present: re-granted after 8 probes
    do_reset();
    LOAD_CXC = 1'b1; CXC_REGISTER = 32'd1;
    tick();
    LOAD_CXC = 1'b0;
    wait_done(1, 20, n);
    chk("self_latency", n, 11);
    chk("self_pid", 32'(CURRENT_PID), 0);
    chk("self_mask", 32'(READY_MASK), 0);
    chk("self_nordy", 32'(NO_READY), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
